// File: rtl/fibo_pkg.sv
// ---------------------------------------------------------------------------
// fibo_pkg
// Shared definitions for the Fibonacci display path.
//   state_t    : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_W      : bits per BCD digit
//   DEF_BIN_W  : default binary width (matches the calculator output)
//   DEF_DIGITS : default BCD digit count (10^DIGITS > 2^BIN_W - 1)
// ---------------------------------------------------------------------------
package fibo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_W      = 4;
    localparam int DEF_BIN_W  = 16;
    localparam int DEF_DIGITS = 5;

endpackage

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
//   digit_i : working BCD digit
//   digit_o : corrected digit
// ---------------------------------------------------------------------------
module bcd_add3
    import fibo_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/fibo_bcd_converter.sv
// ---------------------------------------------------------------------------
// fibo_bcd_converter
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bin_in     : binary value, captured when a conversion starts
//   begin_conv : start request, sampled in IDLE/DONE, ignored in SHIFT
//   busy       : high while shifting
//   done       : high while bcd_out holds a finished result
//   bcd_out    : packed BCD result, digit 0 in bits [3:0]
//   blank      : leading-zero mask (only when BCD_BLANK_EN is defined)
// A conversion takes BIN_W shift edges after the capture edge; bcd_out only
// changes on the last shift edge, so partial results are never visible.
// ---------------------------------------------------------------------------
module fibo_bcd_converter
    import fibo_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [BIN_W-1:0]        bin_in,
    input  logic                    begin_conv,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd_out
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]       blank
`endif
);

    localparam int               BCD_TOT  = BCD_W * DIGITS;
    localparam int               CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);

    state_t             state_q;
    logic [BCD_TOT-1:0] bcd_q;
    logic [BIN_W-1:0]   bin_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_TOT-1:0] bcd_out_q;

    logic [BCD_TOT-1:0] bcd_adj;
    logic [BCD_TOT-1:0] bcd_d;
    logic [BIN_W-1:0]   bin_d;
    logic               last_shift;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .digit_i (bcd_q[gi*BCD_W +: BCD_W]),
                .digit_o (bcd_adj[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Shift {bcd,bin} left by one. The bit leaving the top of the BCD field is
    // always 0 when 10^DIGITS covers the input range; it is rotated into the
    // vacated bin LSB, whose contents are never used.
    assign bcd_d      = {bcd_adj[BCD_TOT-2:0], bin_q[BIN_W-1]};
    assign bin_d      = {bin_q[BIN_W-2:0], bcd_adj[BCD_TOT-1]};
    assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_out_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (begin_conv) begin
                        bin_q   <= bin_in;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_LOAD;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (last_shift) begin
                        bcd_out_q <= bcd_d;
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_out_q;

`ifdef BCD_BLANK_EN
    // blank[i] marks digit i as a leading zero: it and every higher digit are 0.
    // Digit 0 is always shown so a zero result still displays "0".
    logic [DIGITS-1:0] blank_d;
    logic [DIGITS-1:0] blank_q;

    assign blank_d[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign blank_d[gi] = (bcd_d[BCD_TOT-1:gi*BCD_W] == '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else if (last_shift) begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_fibo_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_fibo_bcd_converter
// Self-checking bench for fibo_bcd_converter: directed vector table, random
// values checked against an arithmetic decimal model, and hand sequences for
// held start, mid-run start pulses and reset during a conversion.
// The blank output is checked when BCD_BLANK_EN is defined.
// ---------------------------------------------------------------------------
module tb_fibo_bcd_converter;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic        begin_conv = 1'b0;
    logic [15:0] bin_in     = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
`ifdef BCD_BLANK_EN
    logic [4:0]  blank;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fibo_bcd_converter #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bin_in     (bin_in),
        .begin_conv (begin_conv),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out)
`ifdef BCD_BLANK_EN
        ,
        .blank      (blank)
`endif
    );

    // Decimal digits by plain division.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned rem;
        r   = '0;
        rem = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

    // Digit i is a leading zero exactly when the value is below 10^i.
    function automatic logic [4:0] ref_blank(input int unsigned v);
        logic [4:0]  b;
        int unsigned p;
        b = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p    = p * 10;
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_blank(input string name, input logic [4:0] exp);
`ifdef BCD_BLANK_EN
        check(name, 32'(blank), 32'(exp));
`endif
    endtask

    // Asserts reset, checks outputs with no clock edge in between, releases.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check_blank("rst_blank", 5'b11110);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Starts a conversion at a falling edge. begin_conv stays high for 'hold'
    // rising edges and is re-pulsed (with bin_in=9) at edge pulse_at; bin_in
    // is scrambled after capture. bcd_out must keep 'prior' until done.
    task automatic run_conv(input logic [15:0] v, input int hold, input int pulse_at,
                            input logic [19:0] prior, input logic [19:0] exp_bcd,
                            input logic [4:0] exp_blank);
        int edges;
        edges      = 0;
        bin_in     = v;
        begin_conv = 1'b1;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) break;
            check("busy_in_shift", 32'(busy), 32'd1);
            check("bcd_out_hold", 32'(bcd_out), 32'(prior));
            bin_in     = 16'($urandom);
            begin_conv = (edges < hold) || (edges == pulse_at);
            if (edges == pulse_at) bin_in = 16'd9;
        end
        begin_conv = 1'b0;
        check("latency", 32'(edges), 32'd17);
        check("busy_at_done", 32'(busy), 32'd0);
        check("bcd_result", 32'(bcd_out), 32'(exp_bcd));
        check_blank("blank_result", exp_blank);
        $display("conv bin=%0d bcd_out=%05h expected=%05h edges=%0d", v, bcd_out, exp_bcd, edges);
    endtask

    // Counts rising edges until done, bounded.
    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) break;
        end
    endtask

    typedef struct {
        logic [15:0] bin;
        int          hold;
        int          pulse_at;
        logic        rst_before;
        logic [19:0] bcd;
        logic [4:0]  blank;
    } vec_t;

    vec_t        tbl[8];
    logic [19:0] prior;

    initial begin
        int          e1;
        int          e2;
        int          idle_hits;
        int unsigned rv;

        tbl[0] = '{16'd5,     2, -1, 1'b0, 20'h00005, 5'b11110};
        tbl[1] = '{16'd34,    1, -1, 1'b0, 20'h00034, 5'b11100};
        tbl[2] = '{16'd144,   1, -1, 1'b1, 20'h00144, 5'b11000};
        tbl[3] = '{16'd65535, 1, -1, 1'b0, 20'h65535, 5'b00000};
        tbl[4] = '{16'd0,     1, -1, 1'b0, 20'h00000, 5'b11110};
        tbl[5] = '{16'd9999,  1, -1, 1'b0, 20'h09999, 5'b10000};
        tbl[6] = '{16'd10000, 1, -1, 1'b0, 20'h10000, 5'b00000};
        tbl[7] = '{16'd144,   1,  5, 1'b0, 20'h00144, 5'b11000};

        #2;
        do_reset();
        prior = '0;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst_before) begin
                do_reset();
                prior = '0;
            end
            run_conv(tbl[i].bin, tbl[i].hold, tbl[i].pulse_at, prior, tbl[i].bcd, tbl[i].blank);
            prior = tbl[i].bcd;
        end

        for (int n = 0; n < 20; n++) begin
            rv = $urandom_range(0, 65535);
            run_conv(16'(rv), 1, -1, prior, ref_bcd(rv), ref_blank(rv));
            prior = ref_bcd(rv);
        end

        // begin_conv held high: one restart per completion.
        bin_in     = 16'd34;
        begin_conv = 1'b1;
        wait_done(e1);
        check("held_latency1", 32'(e1), 32'd17);
        check("held_result1", 32'(bcd_out), 32'h00034);
        bin_in = 16'd144;
        @(posedge clk);
        @(negedge clk);
        check("held_restart_done", 32'(done), 32'd0);
        check("held_restart_busy", 32'(busy), 32'd1);
        bin_in = 16'd7;
        wait_done(e2);
        begin_conv = 1'b0;
        check("held_latency2", 32'(e2), 32'd16);
        check("held_result2", 32'(bcd_out), 32'h00144);
        $display("held conv 34 then 144 edges=%0d,%0d bcd_out=%05h", e1, e2 + 1, bcd_out);

        // Reset at shift 8 of a conversion.
        @(negedge clk);
        bin_in     = 16'd65535;
        begin_conv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        begin_conv = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        do_reset();
        idle_hits = 0;
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) idle_hits++;
        end
        check("idle_after_abort", 32'(idle_hits), 32'd0);
        check("bcd_after_abort", 32'(bcd_out), 32'd0);
        $display("abort at shift 8: idle cycles with activity=%0d", idle_hits);
        run_conv(16'd9, 1, -1, 20'h00000, 20'h00009, 5'b11110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
